decstage_pipe: RTL and testbench
================================

DECSTAGE_PIPE -- requirements
Module: decstage_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath and register width; legal values 32..64.
REQ-002 SHALL have parameter REG_N, default 32, meaning number of architectural registers; legal values 2..32.
REQ-003 SHALL have one clock and a synchronous, active-high reset: Clk input 1, rising-edge clock; Rst input 1, synchronous active-high reset.
REQ-004 SHALL have port Instr, input, 32 bits: instruction word.
REQ-005 SHALL have port In_valid, input, 1 bit: Instr and the selects are valid this cycle.
REQ-006 SHALL have port In_ready, output, 1 bit: the stage accepts an instruction this cycle.
REQ-007 SHALL have port RF_B_sel, input, 1 bit: 0 reads B from Instr[15:11]; 1 reads B from Instr[20:16].
REQ-008 SHALL have port ImmExt_sel, input, 2 bits: immediate extension mode.
REQ-009 SHALL have port RF_WrEn, input, 1 bit: write-back enable.
REQ-010 SHALL have port RF_WrAddr, input, 5 bits: write-back register address.
REQ-011 SHALL have port RF_WrData_sel, input, 1 bit: 0 writes ALU_out; 1 writes MEM_out.
REQ-012 SHALL have ports ALU_out and MEM_out, input, DATA_W bits each: write-back sources.
REQ-013 SHALL have ports Out_valid (output, 1 bit) and Out_ready (input, 1 bit): downstream handshake.
REQ-014 SHALL have ports Immed, RF_A and RF_B, output, DATA_W bits each: registered decode results.

Function
REQ-015 SHALL take read address A from Instr[25:21], and read address B from the field selected by RF_B_sel.
REQ-016 SHALL form Immed from Instr[15:0] by ImmExt_sel:
- 00: sign-extend
- 01: zero-extend
- 10: imm placed at bits [31:16], zeros below, upper bits sign-extended from bit 31
- 11: sign-extend, then shift left by 2
REQ-017 SHALL accept an instruction when In_valid and In_ready are both high, and present its results on Out_valid/Immed/RF_A/RF_B on the next cycle (latency 1).
REQ-018 SHALL drive In_ready = !Out_valid || Out_ready, combinationally.
REQ-019 SHALL hold Immed, RF_A and RF_B stable while Out_valid=1 and Out_ready=0.
REQ-020 SHALL clear Out_valid after a transfer (Out_valid and Out_ready both high) when no new instruction is accepted in the same cycle.
REQ-021 SHALL write the selected write-back data to RF_WrAddr on the rising edge when RF_WrEn=1, independent of handshake state.
REQ-022 SHALL ignore writes to register 0 and to addresses >= REG_N.
REQ-023 SHALL read register 0 and addresses >= REG_N as zero.
REQ-024 SHALL resolve a same-cycle write and accept to the same non-zero address as defined in REQ-029/REQ-030.
REQ-025 SHALL, while stalled, not refresh the held RF_A/RF_B from later writes; the upstream stage re-presents the instruction if it needs fresh values.

Reset
REQ-026 SHALL, with Rst=1 at a rising edge, clear every register to 0 and set Out_valid, Immed, RF_A and RF_B to 0.
REQ-027 SHALL give reset priority over a simultaneous write-back or accept, including reset asserted mid-stall; the held instruction is discarded.
REQ-028 SHALL hold In_ready=1 during reset, with no instruction accepted while Rst=1.

Configuration
REQ-029 SHALL, with macro DECSTAGE_BYPASS_EN defined, forward the write-back data to RF_A/RF_B in the same accepting cycle when read address equals RF_WrAddr (non-zero, < REG_N) and RF_WrEn=1.
REQ-030 SHALL, without DECSTAGE_BYPASS_EN, latch the pre-write register value in that case.

Structure
REQ-031 SHALL place the ImmExt_sel encodings, instruction field bit positions and the constant address width 5 in shared package decstage_pkg.
REQ-032 SHALL implement the register file, with its write port and two asynchronous read ports, as sub-module regfile_nr, parametrised by DATA_W and REG_N.

Verification
REQ-033 SHALL cover reset: Rst=1 for 1 cycle -> Out_valid=0, and reads of all registers return 0.
REQ-034 SHALL cover write then read: write ALU_out=0x0000_00AA to r5; next cycle accept Instr with rs=5, RF_B_sel=0, rt=0 -> one cycle later RF_A=0xAA, RF_B=0.
REQ-035 SHALL cover immediate extension: imm=0x800B -> modes 00/01/10/11 give 0xFFFF_800B, 0x0000_800B, 0x800B_0000, 0xFFFE_002C (DATA_W=32).
REQ-036 SHALL cover stall: Out_ready=0 for 3 cycles with In_valid=1 -> In_ready=0 and outputs constant; Out_ready=1 -> one transfer, then the next instruction appears.
REQ-037 SHALL cover the bypass case: r7=0x11, same-cycle write MEM_out=0x22 to r7 and accept rs=7 -> RF_A=0x22 with DECSTAGE_BYPASS_EN, 0x11 without.
REQ-038 SHALL cover r0 and out-of-range addresses: REG_N=16, write 0x55 to r0 and to r20 -> reads of r0 and r20 return 0.

Source files
------------

// File: rtl/decstage_pkg.sv
// rtl/decstage_pkg.sv - instruction field layout, address width and immediate modes for decstage_pipe
package decstage_pkg;

  localparam int ADDR_W  = 5;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  typedef enum logic [1:0] {
    IMM_SEXT = 2'b00,
    IMM_ZEXT = 2'b01,
    IMM_HI   = 2'b10,
    IMM_SHL2 = 2'b11
  } imm_ext_e;

  // Register 0 and anything past the populated file are not real storage.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr, input int reg_n);
    return (addr != '0) && (int'(addr) < reg_n);
  endfunction

endpackage

// File: rtl/decstage_if.sv
// rtl/decstage_if.sv - instruction-in, write-back and decoded-out signal bundle of decstage_pipe
interface decstage_if #(
  parameter int DATA_W = 32
);
  import decstage_pkg::*;

  logic [31:0]        Instr;
  logic               In_valid;
  logic               In_ready;
  logic               RF_B_sel;
  logic [1:0]         ImmExt_sel;
  logic               RF_WrEn;
  logic [ADDR_W-1:0]  RF_WrAddr;
  logic               RF_WrData_sel;
  logic [DATA_W-1:0]  ALU_out;
  logic [DATA_W-1:0]  MEM_out;
  logic               Out_valid;
  logic               Out_ready;
  logic [DATA_W-1:0]  Immed;
  logic [DATA_W-1:0]  RF_A;
  logic [DATA_W-1:0]  RF_B;

  modport master (
    output Instr, In_valid, RF_B_sel, ImmExt_sel, RF_WrEn, RF_WrAddr,
           RF_WrData_sel, ALU_out, MEM_out, Out_ready,
    input  In_ready, Out_valid, Immed, RF_A, RF_B
  );

  modport slave (
    input  Instr, In_valid, RF_B_sel, ImmExt_sel, RF_WrEn, RF_WrAddr,
           RF_WrData_sel, ALU_out, MEM_out, Out_ready,
    output In_ready, Out_valid, Immed, RF_A, RF_B
  );

endinterface

// File: rtl/decstage_pipe_regfile.sv
// rtl/decstage_pipe_regfile.sv - regfile_nr: REG_N x DATA_W register file, one write port, two async read ports
module regfile_nr
  import decstage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  // r0 has no storage; addresses that match no entry simply never hit.
  logic [DATA_W-1:0] regs [1:REG_N-1];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 1; i < REG_N; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 1; i < REG_N; i++) begin
        if (wr_addr == ADDR_W'(i)) regs[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    for (int i = 1; i < REG_N; i++) begin
      if (rd_addr_a == ADDR_W'(i)) rd_data_a = regs[i];
      if (rd_addr_b == ADDR_W'(i)) rd_data_b = regs[i];
    end
  end

endmodule

// File: rtl/decstage_pipe.sv
// rtl/decstage_pipe.sv - decode stage: register read, immediate extension, one-deep valid/ready output register
// Optional macro DECSTAGE_BYPASS_EN forwards same-cycle write-back data to the read operands.
module decstage_pipe
  import decstage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  decstage_if.slave   bus
);

  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [IMM_W-1:0]  imm;
  logic signed [31:0] imm_hi;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              accept;
  logic              out_valid_q;
  logic [DATA_W-1:0] immed_q;
  logic [DATA_W-1:0] rf_a_q;
  logic [DATA_W-1:0] rf_b_q;
  logic              unused_opcode;

  assign addr_a  = bus.Instr[RS_LSB +: ADDR_W];
  assign addr_b  = bus.RF_B_sel ? bus.Instr[RT_LSB +: ADDR_W] : bus.Instr[RD_LSB +: ADDR_W];
  assign imm     = bus.Instr[IMM_LSB +: IMM_W];
  assign imm_hi  = {imm, 16'h0000};
  assign wr_data = bus.RF_WrData_sel ? bus.MEM_out : bus.ALU_out;
  assign unused_opcode = ^bus.Instr[31:26];

  regfile_nr #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_regfile (
    .Clk       (Clk),
    .Rst       (Rst),
    .wr_en     (bus.RF_WrEn),
    .wr_addr   (bus.RF_WrAddr),
    .wr_data   (wr_data),
    .rd_addr_a (addr_a),
    .rd_addr_b (addr_b),
    .rd_data_a (rd_a),
    .rd_data_b (rd_b)
  );

`ifdef DECSTAGE_BYPASS_EN
  assign op_a = (bus.RF_WrEn && bus.RF_WrAddr == addr_a && in_range(addr_a, REG_N)) ? wr_data : rd_a;
  assign op_b = (bus.RF_WrEn && bus.RF_WrAddr == addr_b && in_range(addr_b, REG_N)) ? wr_data : rd_b;
`else
  // The file updates at the same edge the operands are captured, so they see the old value.
  assign op_a = rd_a;
  assign op_b = rd_b;
`endif

  always_comb begin
    imm_ext = '0;
    case (bus.ImmExt_sel)
      IMM_SEXT: imm_ext = DATA_W'($signed(imm));
      IMM_ZEXT: imm_ext = DATA_W'(imm);
      IMM_HI:   imm_ext = DATA_W'(imm_hi);
      IMM_SHL2: imm_ext = DATA_W'($signed(imm)) << 2;
      default:  imm_ext = '0;
    endcase
  end

  // Ready is held high through reset so upstream never sees a spurious stall.
  assign bus.In_ready = Rst || !out_valid_q || bus.Out_ready;
  assign accept       = bus.In_valid && bus.In_ready && !Rst;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_valid_q <= 1'b0;
      immed_q     <= '0;
      rf_a_q      <= '0;
      rf_b_q      <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      immed_q     <= imm_ext;
      rf_a_q      <= op_a;
      rf_b_q      <= op_b;
    end else if (bus.Out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.Out_valid = out_valid_q;
  assign bus.Immed     = immed_q;
  assign bus.RF_A      = rf_a_q;
  assign bus.RF_B      = rf_b_q;

endmodule

// File: tb/tb_decstage_pipe.sv
// tb/tb_decstage_pipe.sv - directed and randomized checks of decstage_pipe against a behavioural model
module tb_decstage_pipe;

  logic Clk = 1'b0;
  logic Rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 Clk = ~Clk;

  decstage_if #(.DATA_W(32)) bus ();
  decstage_if #(.DATA_W(32)) bus16 ();

  decstage_pipe #(.DATA_W(32), .REG_N(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  decstage_pipe #(.DATA_W(32), .REG_N(16)) dut16 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus16)
  );

  logic [31:0] ref_rf [32];
  logic        m_valid;
  logic [31:0] m_immed;
  logic [31:0] m_a;
  logic [31:0] m_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [15:0] imm, input logic [1:0] mode);
    int s;
    s = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
    case (mode)
      2'd0:    return 32'(s);
      2'd1:    return {16'h0000, imm};
      2'd2:    return 32'(imm) * 32'd65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  function automatic logic [31:0] wb_data();
    return bus.RF_WrData_sel ? bus.MEM_out : bus.ALU_out;
  endfunction

  function automatic logic [31:0] read_op(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : ref_rf[a];
`ifdef DECSTAGE_BYPASS_EN
    if (bus.RF_WrEn && bus.RF_WrAddr == a && a != 5'd0) v = wb_data();
`endif
    return v;
  endfunction

  task automatic tick();
    logic        acc;
    logic [31:0] ni, na, nb, wd;
    #1;
    chk("in_ready", 32'(bus.In_ready), 32'(!m_valid || bus.Out_ready));
    acc = bus.In_valid && (!m_valid || bus.Out_ready);
    ni = ref_imm(bus.Instr[15:0], bus.ImmExt_sel);
    na = read_op(bus.Instr[25:21]);
    nb = read_op(bus.RF_B_sel ? bus.Instr[20:16] : bus.Instr[15:11]);
    wd = wb_data();
    @(posedge Clk);
    if (bus.RF_WrEn && bus.RF_WrAddr != 5'd0) ref_rf[bus.RF_WrAddr] = wd;
    if (acc) begin
      m_valid = 1'b1;
      m_immed = ni;
      m_a     = na;
      m_b     = nb;
    end else if (bus.Out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(bus.Out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("immed", bus.Immed, m_immed);
      chk("rf_a", bus.RF_A, m_a);
      chk("rf_b", bus.RF_B, m_b);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.In_ready), 32'd1);
    @(posedge Clk);
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    m_valid = 1'b0;
    #1;
    Rst = 1'b0;
    chk("rst_out_valid", 32'(bus.Out_valid), 32'd0);
    chk("rst_immed", bus.Immed, 32'd0);
    chk("rst_rf_a", bus.RF_A, 32'd0);
    chk("rst_rf_b", bus.RF_B, 32'd0);
  endtask

  initial begin
    logic [31:0] imm_tab [4];
    logic [31:0] instr_b;
    imm_tab = '{32'hFFFF_800B, 32'h0000_800B, 32'h800B_0000, 32'hFFFE_002C};

    bus.Instr = '0; bus.In_valid = 1'b0; bus.RF_B_sel = 1'b0; bus.ImmExt_sel = 2'd0;
    bus.RF_WrEn = 1'b0; bus.RF_WrAddr = '0; bus.RF_WrData_sel = 1'b0;
    bus.ALU_out = '0; bus.MEM_out = '0; bus.Out_ready = 1'b1;
    bus16.Instr = '0; bus16.In_valid = 1'b0; bus16.RF_B_sel = 1'b0; bus16.ImmExt_sel = 2'd0;
    bus16.RF_WrEn = 1'b0; bus16.RF_WrAddr = '0; bus16.RF_WrData_sel = 1'b0;
    bus16.ALU_out = '0; bus16.MEM_out = '0; bus16.Out_ready = 1'b1;
    m_valid = 1'b0; m_immed = '0; m_a = '0; m_b = '0;
    @(posedge Clk);
    #1;
    do_reset();

    // every register reads zero after reset
    for (int i = 0; i < 32; i++) begin
      bus.Instr = {6'd0, 5'(i), 5'(i), 16'($urandom)};
      bus.RF_B_sel = 1'b1; bus.ImmExt_sel = 2'($urandom); bus.In_valid = 1'b1;
      tick();
      chk("rst_read_a", bus.RF_A, 32'd0);
      chk("rst_read_b", bus.RF_B, 32'd0);
    end

    // write r5 then read it back
    bus.In_valid = 1'b0; bus.RF_WrEn = 1'b1; bus.RF_WrAddr = 5'd5;
    bus.RF_WrData_sel = 1'b0; bus.ALU_out = 32'hAA;
    tick();
    bus.RF_WrEn = 1'b0; bus.Instr = {6'd0, 5'd5, 5'd0, 16'd0};
    bus.RF_B_sel = 1'b0; bus.ImmExt_sel = 2'd0; bus.In_valid = 1'b1;
    tick();
    chk("wr_rd_a", bus.RF_A, 32'hAA);
    chk("wr_rd_b", bus.RF_B, 32'd0);

    // immediate extension modes
    for (int m = 0; m < 4; m++) begin
      bus.Instr = {6'd0, 5'd1, 5'd2, 16'h800B};
      bus.ImmExt_sel = 2'(m);
      tick();
      chk("imm_mode", bus.Immed, imm_tab[m]);
    end

    // three-cycle stall, then one transfer and the next instruction
    bus.Instr = $urandom; bus.Out_ready = 1'b1;
    tick();
    instr_b = {6'd0, 5'd5, 5'd3, 16'h1234};
    bus.Instr = instr_b; bus.ImmExt_sel = 2'd1; bus.Out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      bus.RF_WrEn = 1'b1; bus.RF_WrAddr = 5'd5; bus.ALU_out = $urandom;
      tick();
      chk("stall_in_ready", 32'(bus.In_ready), 32'd0);
    end
    bus.RF_WrEn = 1'b0; bus.Out_ready = 1'b1;
    tick();
    chk("stall_next_immed", bus.Immed, 32'h0000_1234);
    bus.In_valid = 1'b0;
    tick();
    chk("drain_out_valid", 32'(bus.Out_valid), 32'd0);

    // same-cycle write-back and accept on r7
    bus.RF_WrEn = 1'b1; bus.RF_WrAddr = 5'd7; bus.RF_WrData_sel = 1'b0; bus.ALU_out = 32'h11;
    tick();
    bus.RF_WrData_sel = 1'b1; bus.MEM_out = 32'h22;
    bus.Instr = {6'd0, 5'd7, 5'd0, 16'd0}; bus.In_valid = 1'b1;
    tick();
`ifdef DECSTAGE_BYPASS_EN
    chk("bypass_rf_a", bus.RF_A, 32'h22);
`else
    chk("bypass_rf_a", bus.RF_A, 32'h11);
`endif

    // reset during a stall with a pending write: both are discarded
    bus.RF_WrEn = 1'b0; bus.Out_ready = 1'b1; bus.Instr = $urandom;
    tick();
    bus.Out_ready = 1'b0; bus.RF_WrEn = 1'b1; bus.RF_WrAddr = 5'd9;
    bus.RF_WrData_sel = 1'b0; bus.ALU_out = 32'h99;
    do_reset();
    bus.RF_WrEn = 1'b0; bus.Out_ready = 1'b1;
    bus.Instr = {6'd0, 5'd9, 5'd7, 16'd0}; bus.RF_B_sel = 1'b1;
    tick();
    chk("rst_stall_r9", bus.RF_A, 32'd0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      bus.Instr = $urandom;
      bus.In_valid = 1'($urandom_range(0, 1));
      bus.Out_ready = ($urandom_range(0, 3) != 0);
      bus.RF_B_sel = 1'($urandom);
      bus.ImmExt_sel = 2'($urandom);
      bus.RF_WrEn = 1'($urandom);
      bus.RF_WrAddr = ($urandom_range(0, 3) == 0) ? bus.Instr[25:21] : 5'($urandom);
      bus.RF_WrData_sel = 1'($urandom);
      bus.ALU_out = $urandom;
      bus.MEM_out = $urandom;
      tick();
    end

    // REG_N=16 instance: r0 and r20 ignore writes and read as zero
    bus.In_valid = 1'b0; bus.RF_WrEn = 1'b0; bus.Out_ready = 1'b1;
    do_reset();
    bus16.RF_WrEn = 1'b1; bus16.ALU_out = 32'h55; bus16.RF_WrAddr = 5'd0;
    @(posedge Clk); #1;
    bus16.RF_WrAddr = 5'd20;
    @(posedge Clk); #1;
    bus16.RF_WrAddr = 5'd3; bus16.ALU_out = 32'h33;
    @(posedge Clk); #1;
    bus16.RF_WrEn = 1'b0; bus16.RF_B_sel = 1'b1;
    bus16.Instr = {6'd0, 5'd0, 5'd20, 16'd0}; bus16.In_valid = 1'b1;
    @(posedge Clk); #1;
    chk("r16_valid", 32'(bus16.Out_valid), 32'd1);
    chk("r16_r0", bus16.RF_A, 32'd0);
    chk("r16_r20_b", bus16.RF_B, 32'd0);
    bus16.Instr = {6'd0, 5'd20, 5'd3, 16'd0};
    @(posedge Clk); #1;
    chk("r16_r20_a", bus16.RF_A, 32'd0);
    chk("r16_r3", bus16.RF_B, 32'h33);
    bus16.In_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
